// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, instruction
// fields, ALU select codes and datapath mux codes.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11,
        S_FAULT    = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [4:0] {
        ALU_ADD = 5'd0,
        ALU_SUB = 5'd1,
        ALU_AND = 5'd2,
        ALU_OR  = 5'd3,
        ALU_SLT = 5'd4
    } alu_sel_t;

    // Which ALU operation a state needs: fixed add, fixed subtract, or funct-driven.
    typedef enum logic [1:0] {
        ACLS_ADD   = 2'd0,
        ACLS_SUB   = 2'd1,
        ACLS_FUNCT = 2'd2
    } alu_class_t;

    localparam logic [1:0] SRCB_RD2     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PC_ALURES = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    function automatic logic is_mem_state(state_t s);
        return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle: instruction fields and status in, enables and
// mux selects out. The datapath side is the master.
interface multicycle_control_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       memReady;
    logic       pcWrite;
    logic       irWrite;
    logic       regWrite;
    logic       memRead;
    logic       memWrite;
    logic       iOrD;
    logic       regDst;
    logic       memToReg;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] pcSrc;
    logic [4:0] aluSelect;
    logic       fault;
    logic [3:0] state;

    modport master (
        output op, funct, zero, memReady,
        input  pcWrite, irWrite, regWrite, memRead, memWrite,
        input  iOrD, regDst, memToReg, aluSrcA, aluSrcB, pcSrc,
        input  aluSelect, fault, state
    );

    modport slave (
        input  op, funct, zero, memReady,
        output pcWrite, irWrite, regWrite, memRead, memWrite,
        output iOrD, regDst, memToReg, aluSrcA, aluSrcB, pcSrc,
        output aluSelect, fault, state
    );
endinterface

// File: rtl/alu_decoder.sv
// Combinational ALU operation select from the controller's state class and the
// R-type funct field; flags funct codes the ALU does not implement.
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  alu_class_t alu_class_i,
    input  logic [5:0] funct_i,
    output alu_sel_t   alu_sel_o,
    output logic       funct_ok_o
);

    always_comb begin
        alu_sel_o  = ALU_ADD;
        funct_ok_o = 1'b1;
        case (alu_class_i)
            ACLS_SUB: alu_sel_o = ALU_SUB;
            ACLS_FUNCT: begin
                case (funct_i)
                    FN_ADD:  alu_sel_o = ALU_ADD;
                    FN_SUB:  alu_sel_o = ALU_SUB;
                    FN_AND:  alu_sel_o = ALU_AND;
                    FN_OR:   alu_sel_o = ALU_OR;
                    FN_SLT:  alu_sel_o = ALU_SLT;
                    default: funct_ok_o = 1'b0;
                endcase
            end
            default: alu_sel_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM with a bounded wait on the unified memory; a
// stalled access or an unknown instruction parks the controller in FAULT.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = 15
) (
    input logic                 clock,
    input logic                 reset_n,
    multicycle_control_if.slave bus
);

    localparam int CW = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fault_q;

    alu_class_t alu_class;
    alu_sel_t   alu_sel;
    logic       funct_ok;
    logic       mem_stall;
    logic       wait_expired;

    always_comb begin
        case (state_q)
            S_EXECUTE: alu_class = ACLS_FUNCT;
            S_BRANCH:  alu_class = ACLS_SUB;
            default:   alu_class = ACLS_ADD;
        endcase
    end

    alu_decoder u_alu_dec (
        .alu_class_i (alu_class),
        .funct_i     (bus.funct),
        .alu_sel_o   (alu_sel),
        .funct_ok_o  (funct_ok)
    );

    assign mem_stall    = is_mem_state(state_q) && !bus.memReady;
    assign wait_expired = mem_stall && (cnt_q == CW'(WAIT_LIMIT));

    always_comb begin
        state_d = state_q;
        if (wait_expired) begin
            state_d = S_FAULT;
        end else begin
            case (state_q)
                S_FETCH:    if (bus.memReady) state_d = S_DECODE;
                S_DECODE: begin
                    case (bus.op)
                        OP_LW, OP_SW: state_d = S_MEMADR;
                        OP_RTYPE:     state_d = S_EXECUTE;
                        OP_BEQ:       state_d = S_BRANCH;
                        OP_ADDI:      state_d = S_ADDIEX;
                        OP_J:         state_d = S_JUMP;
                        default:      state_d = S_FAULT;
                    endcase
                end
                S_MEMADR: begin
                    if (bus.op == OP_LW)      state_d = S_MEMREAD;
                    else if (bus.op == OP_SW) state_d = S_MEMWRITE;
                    else                      state_d = S_FAULT;
                end
                S_MEMREAD:  if (bus.memReady) state_d = S_MEMWB;
                S_MEMWRITE: if (bus.memReady) state_d = S_FETCH;
                S_EXECUTE:  state_d = funct_ok ? S_ALUWB : S_FAULT;
                S_ADDIEX:   state_d = S_ADDIWB;
                S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: state_d = S_FETCH;
                S_FAULT:    state_d = S_FAULT;
                default:    state_d = S_FAULT;
            endcase
        end
    end

    // Counting only continues while the same memory state keeps stalling; any
    // state change (including entry into a memory state) restarts it from zero.
    assign cnt_d = (mem_stall && (state_d == state_q)) ? cnt_q + 1'b1 : '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_q | (state_d == S_FAULT);
        end
    end

    logic       pc_write, ir_write, reg_write, mem_read, mem_write;
    logic       i_or_d, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b, pc_src;

    // Moore decode of state_q, except the FETCH memReady and BRANCH zero terms.
    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RD2;
        pc_src     = PC_ALURES;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = bus.memReady;
                pc_write  = bus.memReady;
            end
            S_DECODE:   alu_src_b = SRCB_IMM_SH2;
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                i_or_d   = 1'b1;
                mem_read = 1'b1;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                i_or_d    = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECUTE:  alu_src_a = 1'b1;
            S_ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                pc_src    = PC_ALUOUT;
                pc_write  = bus.zero;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_ADDIWB:   reg_write = 1'b1;
            S_JUMP: begin
                pc_src   = PC_JUMP;
                pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.pcWrite   = pc_write;
    assign bus.irWrite   = ir_write;
    assign bus.regWrite  = reg_write;
    assign bus.memRead   = mem_read;
    assign bus.memWrite  = mem_write;
    assign bus.iOrD      = i_or_d;
    assign bus.regDst    = reg_dst;
    assign bus.memToReg  = mem_to_reg;
    assign bus.aluSrcA   = alu_src_a;
    assign bus.aluSrcB   = alu_src_b;
    assign bus.pcSrc     = pc_src;
    assign bus.aluSelect = alu_sel;
    assign bus.fault     = fault_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected state and stimulus
// are queued up front, then replayed and compared against a reference table.
module tb_multicycle_control;

    localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3;
    localparam logic [3:0] MEMWB = 4'd4, MEMWRITE = 4'd5, EXECUTE = 4'd6, ALUWB = 4'd7;
    localparam logic [3:0] BRANCH = 4'd8, ADDIEX = 4'd9, ADDIWB = 4'd10, JUMP = 4'd11;
    localparam logic [3:0] FAULT = 4'd12;

    localparam logic [5:0] OPR = 6'b000000, OPLW = 6'b100011, OPSW = 6'b101011;
    localparam logic [5:0] OPBEQ = 6'b000100, OPADDI = 6'b001000, OPJ = 6'b000010;
    localparam logic [5:0] OPBAD = 6'b111111;
    localparam logic [5:0] FADD = 6'b100000, FSUB = 6'b100010, FAND = 6'b100100;
    localparam logic [5:0] FOR = 6'b100101, FSLT = 6'b101010;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    multicycle_control_if bus_if ();

    multicycle_control #(.WAIT_LIMIT(15)) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] st;
        logic       mr;
        logic       z;
        logic [5:0] op;
        logic [5:0] fn;
    } cyc_t;

    cyc_t sb[$];

    // Reference control word for a state, packed as
    // {pcWrite,irWrite,regWrite,memRead,memWrite,iOrD,regDst,memToReg,aluSrcA,aluSrcB,pcSrc,aluSelect,fault}
    function automatic logic [18:0] model_ow(logic [3:0] st, logic mr, logic z, logic [5:0] fn);
        logic pw = 0, iw = 0, rw = 0, mrd = 0, mw = 0, iod = 0, rd = 0, m2r = 0, asa = 0, flt = 0;
        logic [1:0] asb = 2'b00, ps = 2'b00;
        logic [4:0] sel = 5'd0;
        case (st)
            FETCH:    begin mrd = 1; asb = 2'b01; iw = mr; pw = mr; end
            DECODE:   asb = 2'b11;
            MEMADR:   begin asa = 1; asb = 2'b10; end
            MEMREAD:  begin iod = 1; mrd = 1; end
            MEMWB:    begin m2r = 1; rw = 1; end
            MEMWRITE: begin iod = 1; mw = 1; end
            EXECUTE: begin
                asa = 1;
                if (fn == FSUB) sel = 5'd1;
                else if (fn == FAND) sel = 5'd2;
                else if (fn == FOR) sel = 5'd3;
                else if (fn == FSLT) sel = 5'd4;
            end
            ALUWB:    begin rd = 1; rw = 1; end
            BRANCH:   begin asa = 1; sel = 5'd1; ps = 2'b01; pw = z; end
            ADDIEX:   begin asa = 1; asb = 2'b10; end
            ADDIWB:   rw = 1;
            JUMP:     begin ps = 2'b10; pw = 1; end
            FAULT:    flt = 1;
            default: ;
        endcase
        return {pw, iw, rw, mrd, mw, iod, rd, m2r, asa, asb, ps, sel, flt};
    endfunction

    function automatic logic [18:0] obs_ow();
        return {bus_if.pcWrite, bus_if.irWrite, bus_if.regWrite, bus_if.memRead, bus_if.memWrite,
                bus_if.iOrD, bus_if.regDst, bus_if.memToReg, bus_if.aluSrcA, bus_if.aluSrcB,
                bus_if.pcSrc, bus_if.aluSelect, bus_if.fault};
    endfunction

    task automatic push(input logic [3:0] st, input logic mr, input logic z,
                        input logic [5:0] op, input logic [5:0] fn);
        cyc_t c;
        c.st = st; c.mr = mr; c.z = z; c.op = op; c.fn = fn;
        sb.push_back(c);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus_if.memReady = 1'b0;
        bus_if.zero = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_if.memReady = 1'b0;
        #3;
        checks++;
        if ({bus_if.state, obs_ow()} !== {FETCH, model_ow(FETCH, 1'b0, 1'b0, FADD)}) begin
            errors++;
            $display("FAIL reset_idle: state=%0d ctrl=%h, expected state=%0d ctrl=%h",
                     bus_if.state, obs_ow(), FETCH, model_ow(FETCH, 1'b0, 1'b0, FADD));
        end
        bus_if.memReady = 1'b1;
        #1;
        checks++;
        if ({bus_if.state, obs_ow()} !== {FETCH, model_ow(FETCH, 1'b1, 1'b0, FADD)}) begin
            errors++;
            $display("FAIL reset_ready: state=%0d ctrl=%h, expected state=%0d ctrl=%h",
                     bus_if.state, obs_ow(), FETCH, model_ow(FETCH, 1'b1, 1'b0, FADD));
        end
        do_reset();
    endtask

    task automatic test_add();
        cyc_t c;
        int n = 0;
        push(FETCH, 1, 0, OPR, FADD); push(DECODE, 0, 0, OPR, FADD);
        push(EXECUTE, 0, 0, OPR, FADD); push(ALUWB, 0, 0, OPR, FADD);
        push(FETCH, 0, 0, OPR, FADD);
        while (sb.size() != 0) begin
            c = sb.pop_front();
            bus_if.memReady = c.mr; bus_if.zero = c.z; bus_if.op = c.op; bus_if.funct = c.fn;
            @(negedge clk);
            checks++;
            if ({bus_if.state, obs_ow()} !== {c.st, model_ow(c.st, c.mr, c.z, c.fn)}) begin
                errors++;
                $display("FAIL add cyc%0d: state=%0d ctrl=%h, expected state=%0d ctrl=%h",
                         n, bus_if.state, obs_ow(), c.st, model_ow(c.st, c.mr, c.z, c.fn));
            end
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_alu_ops();
        cyc_t c;
        int n = 0;
        logic [5:0] fl [4];
        fl[0] = FSUB; fl[1] = FAND; fl[2] = FOR; fl[3] = FSLT;
        for (int i = 0; i < 4; i++) begin
            push(FETCH, 1, 0, OPR, fl[i]); push(DECODE, 0, 0, OPR, fl[i]);
            push(EXECUTE, 0, 0, OPR, fl[i]); push(ALUWB, 0, 0, OPR, fl[i]);
        end
        push(FETCH, 1, 0, OPR, 6'b000000); push(DECODE, 0, 0, OPR, 6'b000000);
        push(EXECUTE, 0, 0, OPR, 6'b000000); push(FAULT, 1, 0, OPR, 6'b000000);
        push(FAULT, 1, 1, OPR, FADD);
        while (sb.size() != 0) begin
            c = sb.pop_front();
            bus_if.memReady = c.mr; bus_if.zero = c.z; bus_if.op = c.op; bus_if.funct = c.fn;
            @(negedge clk);
            checks++;
            if ({bus_if.state, obs_ow()} !== {c.st, model_ow(c.st, c.mr, c.z, c.fn)}) begin
                errors++;
                $display("FAIL alu_ops cyc%0d: state=%0d ctrl=%h, expected state=%0d ctrl=%h",
                         n, bus_if.state, obs_ow(), c.st, model_ow(c.st, c.mr, c.z, c.fn));
            end
            n++;
            @(posedge clk); #1;
        end
        do_reset();
    endtask

    task automatic test_lw_wait();
        cyc_t c;
        int n = 0;
        push(FETCH, 1, 0, OPLW, FADD); push(DECODE, 0, 0, OPLW, FADD);
        push(MEMADR, 0, 0, OPLW, FADD);
        for (int i = 0; i < 3; i++) push(MEMREAD, 0, 0, OPLW, FADD);
        push(MEMREAD, 1, 0, OPLW, FADD); push(MEMWB, 0, 0, OPLW, FADD);
        push(FETCH, 0, 0, OPLW, FADD);
        while (sb.size() != 0) begin
            c = sb.pop_front();
            bus_if.memReady = c.mr; bus_if.zero = c.z; bus_if.op = c.op; bus_if.funct = c.fn;
            @(negedge clk);
            checks++;
            if ({bus_if.state, obs_ow()} !== {c.st, model_ow(c.st, c.mr, c.z, c.fn)}) begin
                errors++;
                $display("FAIL lw_wait cyc%0d: state=%0d ctrl=%h, expected state=%0d ctrl=%h",
                         n, bus_if.state, obs_ow(), c.st, model_ow(c.st, c.mr, c.z, c.fn));
            end
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sw();
        cyc_t c;
        int n = 0;
        push(FETCH, 1, 0, OPSW, FADD); push(DECODE, 0, 0, OPSW, FADD);
        push(MEMADR, 0, 0, OPSW, FADD);
        push(MEMWRITE, 0, 0, OPSW, FADD); push(MEMWRITE, 0, 0, OPSW, FADD);
        push(MEMWRITE, 1, 0, OPSW, FADD);
        push(FETCH, 1, 0, OPSW, FADD); push(DECODE, 0, 0, OPSW, FADD);
        push(MEMADR, 0, 0, OPSW, FADD);
        for (int i = 0; i < 16; i++) push(MEMWRITE, 0, 0, OPSW, FADD);
        push(FAULT, 0, 0, OPSW, FADD);
        while (sb.size() != 0) begin
            c = sb.pop_front();
            bus_if.memReady = c.mr; bus_if.zero = c.z; bus_if.op = c.op; bus_if.funct = c.fn;
            @(negedge clk);
            checks++;
            if ({bus_if.state, obs_ow()} !== {c.st, model_ow(c.st, c.mr, c.z, c.fn)}) begin
                errors++;
                $display("FAIL sw cyc%0d: state=%0d ctrl=%h, expected state=%0d ctrl=%h",
                         n, bus_if.state, obs_ow(), c.st, model_ow(c.st, c.mr, c.z, c.fn));
            end
            n++;
            @(posedge clk); #1;
        end
        do_reset();
    endtask

    task automatic test_beq();
        cyc_t c;
        int n = 0;
        push(FETCH, 1, 1, OPBEQ, FADD); push(DECODE, 0, 1, OPBEQ, FADD);
        push(BRANCH, 0, 1, OPBEQ, FADD);
        push(FETCH, 1, 0, OPBEQ, FADD); push(DECODE, 0, 1, OPBEQ, FADD);
        push(BRANCH, 0, 0, OPBEQ, FADD);
        push(FETCH, 0, 1, OPBEQ, FADD);
        while (sb.size() != 0) begin
            c = sb.pop_front();
            bus_if.memReady = c.mr; bus_if.zero = c.z; bus_if.op = c.op; bus_if.funct = c.fn;
            @(negedge clk);
            checks++;
            if ({bus_if.state, obs_ow()} !== {c.st, model_ow(c.st, c.mr, c.z, c.fn)}) begin
                errors++;
                $display("FAIL beq cyc%0d: state=%0d ctrl=%h, expected state=%0d ctrl=%h",
                         n, bus_if.state, obs_ow(), c.st, model_ow(c.st, c.mr, c.z, c.fn));
            end
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_addi_jump();
        cyc_t c;
        int n = 0;
        push(FETCH, 1, 0, OPADDI, FSUB); push(DECODE, 0, 0, OPADDI, FSUB);
        push(ADDIEX, 0, 0, OPADDI, FSUB); push(ADDIWB, 0, 0, OPADDI, FSUB);
        push(FETCH, 1, 0, OPJ, FSUB); push(DECODE, 0, 0, OPJ, FSUB);
        push(JUMP, 0, 0, OPJ, FSUB); push(FETCH, 0, 0, OPJ, FSUB);
        while (sb.size() != 0) begin
            c = sb.pop_front();
            bus_if.memReady = c.mr; bus_if.zero = c.z; bus_if.op = c.op; bus_if.funct = c.fn;
            @(negedge clk);
            checks++;
            if ({bus_if.state, obs_ow()} !== {c.st, model_ow(c.st, c.mr, c.z, c.fn)}) begin
                errors++;
                $display("FAIL addi_jump cyc%0d: state=%0d ctrl=%h, expected state=%0d ctrl=%h",
                         n, bus_if.state, obs_ow(), c.st, model_ow(c.st, c.mr, c.z, c.fn));
            end
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_fetch_timeout();
        cyc_t c;
        int n = 0;
        do_reset();
        for (int i = 0; i < 15; i++) push(FETCH, 0, 0, OPR, FADD);
        push(FETCH, 1, 0, OPR, FADD); push(DECODE, 0, 0, OPR, FADD);
        push(EXECUTE, 0, 0, OPR, FADD); push(ALUWB, 0, 0, OPR, FADD);
        push(FETCH, 0, 0, OPR, FADD);
        while (sb.size() != 0) begin
            c = sb.pop_front();
            bus_if.memReady = c.mr; bus_if.zero = c.z; bus_if.op = c.op; bus_if.funct = c.fn;
            @(negedge clk);
            checks++;
            if ({bus_if.state, obs_ow()} !== {c.st, model_ow(c.st, c.mr, c.z, c.fn)}) begin
                errors++;
                $display("FAIL fetch_limit cyc%0d: state=%0d ctrl=%h, expected state=%0d ctrl=%h",
                         n, bus_if.state, obs_ow(), c.st, model_ow(c.st, c.mr, c.z, c.fn));
            end
            n++;
            @(posedge clk); #1;
        end
        do_reset();
        n = 0;
        for (int i = 0; i < 16; i++) push(FETCH, 0, 0, OPR, FADD);
        push(FAULT, 1, 0, OPR, FADD); push(FAULT, 1, 1, OPR, FADD);
        while (sb.size() != 0) begin
            c = sb.pop_front();
            bus_if.memReady = c.mr; bus_if.zero = c.z; bus_if.op = c.op; bus_if.funct = c.fn;
            @(negedge clk);
            checks++;
            if ({bus_if.state, obs_ow()} !== {c.st, model_ow(c.st, c.mr, c.z, c.fn)}) begin
                errors++;
                $display("FAIL fetch_timeout cyc%0d: state=%0d ctrl=%h, expected state=%0d ctrl=%h",
                         n, bus_if.state, obs_ow(), c.st, model_ow(c.st, c.mr, c.z, c.fn));
            end
            n++;
            @(posedge clk); #1;
        end
        do_reset();
    endtask

    task automatic test_bad_op();
        cyc_t c;
        int n = 0;
        push(FETCH, 1, 0, OPBAD, FADD); push(DECODE, 0, 0, OPBAD, FADD);
        push(FAULT, 0, 0, OPBAD, FADD); push(FAULT, 1, 1, OPR, FADD);
        while (sb.size() != 0) begin
            c = sb.pop_front();
            bus_if.memReady = c.mr; bus_if.zero = c.z; bus_if.op = c.op; bus_if.funct = c.fn;
            @(negedge clk);
            checks++;
            if ({bus_if.state, obs_ow()} !== {c.st, model_ow(c.st, c.mr, c.z, c.fn)}) begin
                errors++;
                $display("FAIL bad_op cyc%0d: state=%0d ctrl=%h, expected state=%0d ctrl=%h",
                         n, bus_if.state, obs_ow(), c.st, model_ow(c.st, c.mr, c.z, c.fn));
            end
            n++;
            @(posedge clk); #1;
        end
        bus_if.memReady = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus_if.state, bus_if.fault} !== {FETCH, 1'b0}) begin
            errors++;
            $display("FAIL fault_clear: state=%0d fault=%b, expected state=%0d fault=0",
                     bus_if.state, bus_if.fault, FETCH);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset_mid_sw();
        cyc_t c;
        int n = 0;
        push(FETCH, 1, 0, OPSW, FADD); push(DECODE, 0, 0, OPSW, FADD);
        push(MEMADR, 0, 0, OPSW, FADD);
        while (sb.size() != 0) begin
            c = sb.pop_front();
            bus_if.memReady = c.mr; bus_if.zero = c.z; bus_if.op = c.op; bus_if.funct = c.fn;
            @(negedge clk);
            checks++;
            if ({bus_if.state, obs_ow()} !== {c.st, model_ow(c.st, c.mr, c.z, c.fn)}) begin
                errors++;
                $display("FAIL rst_sw cyc%0d: state=%0d ctrl=%h, expected state=%0d ctrl=%h",
                         n, bus_if.state, obs_ow(), c.st, model_ow(c.st, c.mr, c.z, c.fn));
            end
            n++;
            @(posedge clk); #1;
        end
        bus_if.memReady = 1'b0;
        #2;
        checks++;
        if ({bus_if.state, bus_if.memWrite} !== {MEMWRITE, 1'b1}) begin
            errors++;
            $display("FAIL sw_before_reset: state=%0d memWrite=%b, expected state=%0d memWrite=1",
                     bus_if.state, bus_if.memWrite, MEMWRITE);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus_if.state, bus_if.memWrite, bus_if.fault} !== {FETCH, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: state=%0d memWrite=%b fault=%b, expected state=%0d memWrite=0 fault=0",
                     bus_if.state, bus_if.memWrite, bus_if.fault, FETCH);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        bus_if.op = OPR;
        bus_if.funct = FADD;
        bus_if.zero = 1'b0;
        bus_if.memReady = 1'b0;
        test_reset();
        test_add();
        test_alu_ops();
        test_lw_wait();
        test_sw();
        test_beq();
        test_addi_jump();
        test_fetch_timeout();
        test_bad_op();
        test_reset_mid_sw();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
